// File: rtl/ball_logic_pkg.sv
// Shared definitions for the pong ball-position generator.
// Covers position width, compare width and the step-direction encoding.
package ball_logic_pkg;

   localparam int unsigned POS_W = 9;
   localparam int unsigned CMP_W = POS_W + 1;

   // Encoded so that the value equals the sign bit of a two's-complement step
   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_e;

   function automatic logic [POS_W-1:0] step_of(input dir_e d, input int unsigned spd);
      logic [POS_W-1:0] s;
      s = POS_W'(spd);
      return (d == DIR_NEG) ? -s : s;
   endfunction

endpackage

// File: rtl/ball_logic_if.sv
// Ball-position bus from the generator to the renderer/collision logic.
interface ball_logic_if;
   import ball_logic_pkg::*;

   logic [POS_W-1:0] ball_hpos;
   logic [POS_W-1:0] ball_vpos;

   modport master (output ball_hpos, output ball_vpos);
   modport slave  (input  ball_hpos, input  ball_vpos);

endinterface

// File: rtl/ball_logic_axis.sv
// One bouncing axis: position walks by +/-SPEED per clock, clamped at 0 and MAX.
module ball_axis
   import ball_logic_pkg::*;
#(
   parameter int unsigned MAX   = 240,
   parameter int unsigned SPEED = 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic [POS_W-1:0] pos,
   output logic [POS_W-1:0] move,
   output logic             collide
);

   localparam logic [CMP_W-1:0] C_MAX    = CMP_W'(MAX);
   localparam logic [CMP_W-1:0] C_SPD    = CMP_W'(SPEED);
   localparam logic [POS_W-1:0] P_MAX    = POS_W'(MAX);
   localparam logic [POS_W-1:0] STEP_POS = step_of(DIR_POS, SPEED);
   localparam logic [POS_W-1:0] STEP_NEG = step_of(DIR_NEG, SPEED);

   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] r_move;
   logic             r_collide;
   dir_e             w_dir;
   logic [CMP_W-1:0] w_pos_ext;

   assign w_dir     = dir_e'(r_move[POS_W-1]);
   assign w_pos_ext = {1'b0, r_pos};

   // Wall tests use the widened position so pos+SPEED cannot wrap near 511
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pos     <= P_MAX;
         r_move    <= STEP_NEG;
         r_collide <= 1'b0;
      end else if (w_dir == DIR_NEG && w_pos_ext <= C_SPD) begin
         r_pos     <= '0;
         r_move    <= STEP_POS;
         r_collide <= 1'b1;
      end else if (w_dir == DIR_POS && (w_pos_ext + C_SPD) >= C_MAX) begin
         r_pos     <= P_MAX;
         r_move    <= STEP_NEG;
         r_collide <= 1'b1;
      end else begin
         r_pos     <= r_pos + r_move;
         r_collide <= 1'b0;
      end
   end

   assign pos     = r_pos;
   assign move    = r_move;
   assign collide = r_collide;

endmodule

// File: rtl/ball_logic.sv
// Autonomous ball-position generator: two independent bouncing axes.
module ball_logic
   import ball_logic_pkg::*;
#(
   parameter int unsigned H_MAX      = 240,
   parameter int unsigned V_MAX      = 224,
   parameter int unsigned BALL_SPEED = 1
) (
   input  logic             clk,
   input  logic             reset,
   output logic [POS_W-1:0] ball_hpos,
   output logic [POS_W-1:0] ball_vpos
);

   logic [POS_W-1:0] ball_horiz_move;
   logic [POS_W-1:0] ball_vert_move;
   logic             ball_horiz_collide;
   logic             ball_vert_collide;

   ball_axis #(
      .MAX   (H_MAX),
      .SPEED (BALL_SPEED)
   ) u_horiz (
      .clk     (clk),
      .reset   (reset),
      .pos     (ball_hpos),
      .move    (ball_horiz_move),
      .collide (ball_horiz_collide)
   );

   ball_axis #(
      .MAX   (V_MAX),
      .SPEED (BALL_SPEED)
   ) u_vert (
      .clk     (clk),
      .reset   (reset),
      .pos     (ball_vpos),
      .move    (ball_vert_move),
      .collide (ball_vert_collide)
   );

endmodule

// File: tb/tb_ball_logic.sv
// Scoreboard bench for ball_logic: three parameterisations checked against a behavioural model.
module tb_ball_logic;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   ball_logic_if if_a ();
   ball_logic_if if_b ();
   ball_logic_if if_c ();

   ball_logic #(.H_MAX(20), .V_MAX(20), .BALL_SPEED(2)) dut_a (
      .clk(clk), .reset(reset), .ball_hpos(if_a.ball_hpos), .ball_vpos(if_a.ball_vpos));
   ball_logic #(.H_MAX(21), .V_MAX(20), .BALL_SPEED(2)) dut_b (
      .clk(clk), .reset(reset), .ball_hpos(if_b.ball_hpos), .ball_vpos(if_b.ball_vpos));
   ball_logic #(.H_MAX(20), .V_MAX(10), .BALL_SPEED(2)) dut_c (
      .clk(clk), .reset(reset), .ball_hpos(if_c.ball_hpos), .ball_vpos(if_c.ball_vpos));

   typedef struct {
      int         id;
      logic [8:0] hp, vp, hm, vm;
      logic       hc, vc;
   } exp_t;

   exp_t exp_q[$];
   int   vecs = 0;
   int   errs = 0;

   // Model state per DUT: index 0=a, 1=b, 2=c
   int   m_hp[3], m_vp[3], m_hm[3], m_vm[3];
   bit   m_hc[3], m_vc[3];
   int   hmax[3] = '{20, 21, 20};
   int   vmax[3] = '{20, 20, 10};
   int   spd = 2;

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d (0x%03h) expected=%0d (0x%03h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic axis_step(input int pos, input int mv, input int mx,
                            output int np, output int nm, output bit col);
      if (mv < 0 && pos <= spd) begin
         np = 0; nm = spd; col = 1'b1;
      end else if (mv > 0 && pos + spd >= mx) begin
         np = mx; nm = -spd; col = 1'b1;
      end else begin
         np = pos + mv; nm = mv; col = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_hp[i] = hmax[i]; m_vp[i] = vmax[i];
         m_hm[i] = -spd;    m_vm[i] = -spd;
         m_hc[i] = 1'b0;    m_vc[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int np, nm;
      bit c;
      for (int i = 0; i < 3; i++) begin
         axis_step(m_hp[i], m_hm[i], hmax[i], np, nm, c);
         m_hp[i] = np; m_hm[i] = nm; m_hc[i] = c;
         axis_step(m_vp[i], m_vm[i], vmax[i], np, nm, c);
         m_vp[i] = np; m_vm[i] = nm; m_vc[i] = c;
      end
   endtask

   task automatic push_all();
      exp_t e;
      int   t;
      for (int i = 0; i < 3; i++) begin
         e.id = i;
         e.hp = m_hp[i][8:0]; e.vp = m_vp[i][8:0];
         t = m_hm[i]; e.hm = t[8:0];
         t = m_vm[i]; e.vm = t[8:0];
         e.hc = m_hc[i]; e.vc = m_vc[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic pop_compare(input string step);
      exp_t e;
      logic [8:0] hp, vp, hm, vm;
      logic hc, vc;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.id)
            0: begin hp = if_a.ball_hpos; vp = if_a.ball_vpos; hm = dut_a.ball_horiz_move;
                     vm = dut_a.ball_vert_move; hc = dut_a.ball_horiz_collide; vc = dut_a.ball_vert_collide; end
            1: begin hp = if_b.ball_hpos; vp = if_b.ball_vpos; hm = dut_b.ball_horiz_move;
                     vm = dut_b.ball_vert_move; hc = dut_b.ball_horiz_collide; vc = dut_b.ball_vert_collide; end
            default: begin hp = if_c.ball_hpos; vp = if_c.ball_vpos; hm = dut_c.ball_horiz_move;
                     vm = dut_c.ball_vert_move; hc = dut_c.ball_horiz_collide; vc = dut_c.ball_vert_collide; end
         endcase
         check($sformatf("%s dut%0d hpos", step, e.id), hp, e.hp);
         check($sformatf("%s dut%0d vpos", step, e.id), vp, e.vp);
         check($sformatf("%s dut%0d hmove", step, e.id), hm, e.hm);
         check($sformatf("%s dut%0d vmove", step, e.id), vm, e.vm);
         check($sformatf("%s dut%0d hcol", step, e.id), {8'd0, hc}, {8'd0, e.hc});
         check($sformatf("%s dut%0d vcol", step, e.id), {8'd0, vc}, {8'd0, e.vc});
      end
   endtask

   task automatic run_edges(input int n, input string step);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         push_all();
         #1;
         pop_compare($sformatf("%s e%0d", step, k + 1));
      end
   endtask

   initial begin
      // Reset held across several edges: values must hold
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      push_all();
      pop_compare("reset");
      check("reset a hpos const", if_a.ball_hpos, 9'd20);
      check("reset a hmove const", dut_a.ball_horiz_move, 9'h1FE);

      @(negedge clk);
      reset = 1'b1;

      // Covers lower/upper bounces for all three, corner for dut_c at edge 20
      run_edges(20, "run1");
      check("corner c hcol", {8'd0, dut_c.ball_horiz_collide}, 9'd1);
      check("corner c vcol", {8'd0, dut_c.ball_vert_collide}, 9'd1);
      check("period a hpos", if_a.ball_hpos, 9'd20);
      run_edges(25, "run2");

      // Fresh start, then reset mid-flight between edges at hpos=8
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      push_all();
      pop_compare("rst2");
      @(negedge clk);
      reset = 1'b1;
      run_edges(6, "pre");
      check("midflight a hpos before", if_a.ball_hpos, 9'd8);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      push_all();
      pop_compare("async");
      @(posedge clk);
      #1;
      push_all();
      pop_compare("hold");
      @(negedge clk);
      reset = 1'b1;
      run_edges(12, "post");

      check("scoreboard drained", 9'(exp_q.size()), 9'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
